mem_arbiter: RTL and testbench

- Two-port arbiter that shares the single-port SoC memory between the CPU (port 0) and a second master such as a UART loader or debug/DMA engine (port 1).
- Sequences each access: grant, memory drive, fixed read-latency wait, then a one-cycle acknowledge with read data.
- Sits in the SoC between the requesters and the memory block. The CPU's fixed-latency fetch/load/store sequencing is replaced by req/ack handshakes through this block.

---
 rtl/soc_pkg.sv | 14 +
 rtl/rr_pick2.sv | 22 ++
 rtl/mem_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_pkg.sv
// Shared SoC definitions: memory arbiter state encodings and requester port indices.
package soc_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_WAIT   = 2'd2,
        ARB_RESP   = 2'd3
    } arb_state_e;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_AUX = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Two-way grant selector: round-robin on ties, or port 0 always wins ties when FIXED_PRIO != 0.
module rr_pick2
    import soc_pkg::*;
#(
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_last_served,
    output logic o_grant_c
);

    always_comb begin
        o_grant_c = PORT_CPU;
        if (i_req0 && i_req1) begin
            o_grant_c = (FIXED_PRIO != 0) ? PORT_CPU : ~i_last_served;
        end else if (i_req1) begin
            o_grant_c = PORT_AUX;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between two req/ack masters: grant, drive, fixed-latency
// wait, then a one-cycle registered acknowledge carrying read data.
module mem_arbiter
    import soc_pkg::*;
#(
    parameter int unsigned AW         = 7,
    parameter int unsigned DW         = 32,
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req0,
    input  logic          i_req1,
    input  logic          i_rw0,
    input  logic          i_rw1,
    input  logic [31:0]   i_addr0,
    input  logic [31:0]   i_addr1,
    input  logic [DW-1:0] i_wdata0,
    input  logic [DW-1:0] i_wdata1,
    output logic          o_ack0,
    output logic          o_ack1,
    output logic [DW-1:0] o_rdata0,
    output logic [DW-1:0] o_rdata1,
    output logic [AW-1:0] o_mem_addr,
    output logic [DW-1:0] o_mem_wdata,
    output logic          o_mem_wre,
    input  logic [DW-1:0] i_mem_rdata
);

    localparam int unsigned CW      = 3;
    localparam bit          LAT_ONE = (MEM_LAT <= 1);

    arb_state_e    state_q, state_d;
    logic          owner_q, owner_d;
    logic          last_served_q, last_served_d;
    logic          rw_q, rw_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ack0_q, ack0_d;
    logic          ack1_q, ack1_d;
    logic [DW-1:0] rdata0_q, rdata0_d;
    logic [DW-1:0] rdata1_q, rdata1_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          mem_wre_q, mem_wre_d;
    logic          grant_c;

    // Upper address bits are intentionally ignored by the word-addressed memory.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_addr0[31:AW], i_addr1[31:AW]};

    rr_pick2 #(.FIXED_PRIO(FIXED_PRIO)) u_pick (
        .i_req0        (i_req0),
        .i_req1        (i_req1),
        .i_last_served (last_served_q),
        .o_grant_c     (grant_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ARB_IDLE;
            owner_q       <= PORT_CPU;
            last_served_q <= PORT_AUX;
            rw_q          <= 1'b0;
            cnt_q         <= '0;
            ack0_q        <= 1'b0;
            ack1_q        <= 1'b0;
            rdata0_q      <= '0;
            rdata1_q      <= '0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            mem_wre_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            last_served_q <= last_served_d;
            rw_q          <= rw_d;
            cnt_q         <= cnt_d;
            ack0_q        <= ack0_d;
            ack1_q        <= ack1_d;
            rdata0_q      <= rdata0_d;
            rdata1_q      <= rdata1_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_wre_q     <= mem_wre_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARB_IDLE:   if (i_req0 || i_req1) state_d = ARB_ACCESS;
            ARB_ACCESS: state_d = (rw_q || LAT_ONE) ? ARB_RESP : ARB_WAIT;
            ARB_WAIT:   if (cnt_q <= CW'(1)) state_d = ARB_RESP;
            ARB_RESP:   state_d = ARB_IDLE;
            default:    state_d = ARB_IDLE;
        endcase
    end

    // Writes acknowledge as the strobe ends; reads acknowledge when data is captured in RESP.
    always_comb begin
        owner_d       = owner_q;
        last_served_d = last_served_q;
        rw_d          = rw_q;
        cnt_d         = cnt_q;
        ack0_d        = 1'b0;
        ack1_d        = 1'b0;
        rdata0_d      = rdata0_q;
        rdata1_d      = rdata1_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        mem_wre_d     = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                if (i_req0 || i_req1) begin
                    owner_d     = grant_c;
                    rw_d        = grant_c ? i_rw1 : i_rw0;
                    mem_addr_d  = grant_c ? i_addr1[AW-1:0] : i_addr0[AW-1:0];
                    mem_wdata_d = grant_c ? i_wdata1 : i_wdata0;
                    mem_wre_d   = grant_c ? i_rw1 : i_rw0;
                end
            end
            ARB_ACCESS: begin
                if (!LAT_ONE) cnt_d = CW'(MEM_LAT - 1);
                if (rw_q) begin
                    ack0_d = (owner_q == PORT_CPU);
                    ack1_d = (owner_q == PORT_AUX);
                end
            end
            ARB_WAIT: begin
                cnt_d = cnt_q - CW'(1);
            end
            ARB_RESP: begin
                last_served_d = owner_q;
                if (!rw_q) begin
                    ack0_d = (owner_q == PORT_CPU);
                    ack1_d = (owner_q == PORT_AUX);
                    if (owner_q == PORT_AUX) rdata1_d = i_mem_rdata;
                    else                     rdata0_d = i_mem_rdata;
                end
            end
            default: ;
        endcase
    end

    assign o_ack0      = ack0_q;
    assign o_ack1      = ack1_q;
    assign o_rdata0    = rdata0_q;
    assign o_rdata1    = rdata1_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_wdata = mem_wdata_q;
    assign o_mem_wre   = mem_wre_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: three instances (LAT1 round-robin, LAT3 round-robin,
// LAT1 fixed priority) share stimulus, each with its own synchronous memory model.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        req0, req1, rw0, rw1;
    logic [31:0] addr0, addr1, wdata0, wdata1;

    logic        ack0   [3];
    logic        ack1   [3];
    logic [31:0] rdata0 [3];
    logic [31:0] rdata1 [3];
    logic [6:0]  maddr  [3];
    logic [31:0] mwdata [3];
    logic        mwre   [3];
    logic [31:0] mrdata [3];

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] init_word(input logic [6:0] a);
        return (a == 7'd4) ? 32'h0000_0013 : {16'hA5A5, 9'd0, a};
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned G_LAT = (g == 1) ? 3 : 1;
        localparam int unsigned G_FP  = (g == 2) ? 1 : 0;

        logic [31:0] mem  [128];
        logic [31:0] pipe [8];

        // Synchronous memory: data valid G_LAT cycles after the address is presented.
        always @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < 128; i++) mem[i] <= init_word(7'(i));
            end else if (mwre[g]) begin
                mem[maddr[g]] <= mwdata[g];
            end
            pipe[0] <= mem[maddr[g]];
            for (int i = 1; i < 8; i++) pipe[i] <= pipe[i-1];
        end
        assign mrdata[g] = pipe[G_LAT-1];

        mem_arbiter #(.AW(7), .DW(32), .MEM_LAT(G_LAT), .FIXED_PRIO(G_FP)) u_dut (
            .clk         (clk),
            .rst         (rst),
            .i_req0      (req0),
            .i_req1      (req1),
            .i_rw0       (rw0),
            .i_rw1       (rw1),
            .i_addr0     (addr0),
            .i_addr1     (addr1),
            .i_wdata0    (wdata0),
            .i_wdata1    (wdata1),
            .o_ack0      (ack0[g]),
            .o_ack1      (ack1[g]),
            .o_rdata0    (rdata0[g]),
            .o_rdata1    (rdata1[g]),
            .o_mem_addr  (maddr[g]),
            .o_mem_wdata (mwdata[g]),
            .o_mem_wre   (mwre[g]),
            .i_mem_rdata (mrdata[g])
        );
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req0 = 1'b0;
        req1 = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (ack0[k] !== 1'b0 || ack1[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset_ack inst%0d got %0b%0b want 00", k, ack0[k], ack1[k]);
            end
            checks++;
            if (rdata0[k] !== 32'h0 || rdata1[k] !== 32'h0) begin
                errors++;
                $display("FAIL reset_rdata inst%0d got %h %h want 0 0", k, rdata0[k], rdata1[k]);
            end
            checks++;
            if (maddr[k] !== 7'h0 || mwdata[k] !== 32'h0 || mwre[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset_mem inst%0d got addr %h wdata %h wre %0b want 0 0 0",
                         k, maddr[k], mwdata[k], mwre[k]);
            end
        end
    endtask

    task automatic test_read_lat1();
        req0 = 1'b1; rw0 = 1'b0; addr0 = 32'h4;
        step();
        checks++;
        if (maddr[0] !== 7'h04 || mwre[0] !== 1'b0) begin
            errors++;
            $display("FAIL rd1_drive got addr %h wre %0b want 04 0", maddr[0], mwre[0]);
        end
        step();
        checks++;
        if (ack0[0] !== 1'b0 || ack1[0] !== 1'b0) begin
            errors++;
            $display("FAIL rd1_early_ack got %0b%0b want 00", ack0[0], ack1[0]);
        end
        step();
        checks++;
        if (ack0[0] !== 1'b1 || ack1[0] !== 1'b0) begin
            errors++;
            $display("FAIL rd1_ack got ack0 %0b ack1 %0b want 1 0", ack0[0], ack1[0]);
        end
        checks++;
        if (rdata0[0] !== 32'h0000_0013) begin
            errors++;
            $display("FAIL rd1_data got %h want 00000013", rdata0[0]);
        end
        req0 = 1'b0;
        step();
        checks++;
        if (ack0[0] !== 1'b0) begin
            errors++;
            $display("FAIL rd1_pulse got %0b want 0", ack0[0]);
        end
    endtask

    task automatic test_write_then_read();
        req1 = 1'b1; rw1 = 1'b1; addr1 = 32'h10; wdata1 = 32'hDEAD_BEEF;
        step();
        checks++;
        if (mwre[0] !== 1'b1 || maddr[0] !== 7'h10 || mwdata[0] !== 32'hDEAD_BEEF || ack1[0] !== 1'b0) begin
            errors++;
            $display("FAIL wr_strobe got wre %0b addr %h wdata %h ack1 %0b want 1 10 deadbeef 0",
                     mwre[0], maddr[0], mwdata[0], ack1[0]);
        end
        step();
        checks++;
        if (mwre[0] !== 1'b0 || ack1[0] !== 1'b1 || ack0[0] !== 1'b0) begin
            errors++;
            $display("FAIL wr_ack got wre %0b ack1 %0b ack0 %0b want 0 1 0", mwre[0], ack1[0], ack0[0]);
        end
        req1 = 1'b0; rw1 = 1'b0;
        step();
        checks++;
        if (ack1[0] !== 1'b0 || mwre[0] !== 1'b0) begin
            errors++;
            $display("FAIL wr_pulse got ack1 %0b wre %0b want 0 0", ack1[0], mwre[0]);
        end
        req0 = 1'b1; rw0 = 1'b0; addr0 = 32'h10;
        step();
        step();
        step();
        checks++;
        if (ack0[0] !== 1'b1 || rdata0[0] !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL wr_readback got ack0 %0b data %h want 1 deadbeef", ack0[0], rdata0[0]);
        end
        checks++;
        if (rdata1[0] !== 32'h0) begin
            errors++;
            $display("FAIL wr_rdata1_kept got %h want 0", rdata1[0]);
        end
        req0 = 1'b0;
        step();
    endtask

    task automatic test_round_robin();
        int n0 = 0;
        int n2 = 0;
        int ord0 [4] = '{9, 9, 9, 9};
        int ord2 [4] = '{9, 9, 9, 9};
        bit both = 1'b0;
        do_reset();
        req0 = 1'b1; rw0 = 1'b0; addr0 = 32'h4;
        req1 = 1'b1; rw1 = 1'b0; addr1 = 32'h5;
        for (int c = 0; c < 24 && (n0 < 4 || n2 < 4); c++) begin
            step();
            if (ack0[0] && ack1[0]) both = 1'b1;
            if (ack0[2] && ack1[2]) both = 1'b1;
            if (ack0[0] && n0 < 4) begin ord0[n0] = 0; n0++; end
            if (ack1[0] && n0 < 4) begin ord0[n0] = 1; n0++; end
            if (ack0[2] && n2 < 4) begin ord2[n2] = 0; n2++; end
            if (ack1[2] && n2 < 4) begin ord2[n2] = 1; n2++; end
        end
        checks++;
        if (n0 != 4 || n2 != 4) begin
            errors++;
            $display("FAIL rr_timeout got acks %0d %0d want 4 4", n0, n2);
        end
        checks++;
        if (both) begin
            errors++;
            $display("FAIL rr_exclusive got simultaneous acks want none");
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ord0[i] != (i % 2)) begin
                errors++;
                $display("FAIL rr_order idx %0d got port %0d want %0d", i, ord0[i], i % 2);
            end
            checks++;
            if (ord2[i] != 0) begin
                errors++;
                $display("FAIL fp_order idx %0d got port %0d want 0", i, ord2[i]);
            end
        end
        checks++;
        if (rdata1[0] !== 32'hA5A5_0005 || rdata1[2] !== 32'h0 || rdata0[2] !== 32'h0000_0013) begin
            errors++;
            $display("FAIL rr_data got %h %h %h want a5a50005 0 00000013", rdata1[0], rdata1[2], rdata0[2]);
        end
        req0 = 1'b0; req1 = 1'b0;
        step();
        step();
    endtask

    task automatic test_lat3();
        do_reset();
        req0 = 1'b1; rw0 = 1'b0; addr0 = 32'h7;
        for (int i = 1; i <= 4; i++) begin
            step();
            checks++;
            if (ack0[1] !== 1'b0) begin
                errors++;
                $display("FAIL lat3_early cycle %0d got %0b want 0", i, ack0[1]);
            end
        end
        step();
        checks++;
        if (ack0[1] !== 1'b1 || rdata0[1] !== 32'hA5A5_0007) begin
            errors++;
            $display("FAIL lat3_ack got ack0 %0b data %h want 1 a5a50007", ack0[1], rdata0[1]);
        end
        req0 = 1'b0;
        step();
        checks++;
        if (ack0[1] !== 1'b0) begin
            errors++;
            $display("FAIL lat3_pulse got %0b want 0", ack0[1]);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req1 = 1'b1; rw1 = 1'b0; addr1 = 32'h8;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        req0 = 1'b1; rw0 = 1'b0; addr0 = 32'h4;
        checks++;
        if (ack1[0] !== 1'b0 || mwre[0] !== 1'b0 || maddr[0] !== 7'h0) begin
            errors++;
            $display("FAIL rstmid_state got ack1 %0b wre %0b addr %h want 0 0 0", ack1[0], mwre[0], maddr[0]);
        end
        for (int i = 1; i <= 2; i++) begin
            step();
            checks++;
            if (ack0[0] !== 1'b0 || ack1[0] !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_noack cycle %0d got %0b%0b want 00", i, ack0[0], ack1[0]);
            end
        end
        step();
        checks++;
        if (ack0[0] !== 1'b1 || ack1[0] !== 1'b0 || rdata0[0] !== 32'h0000_0013) begin
            errors++;
            $display("FAIL rstmid_first got ack0 %0b ack1 %0b data %h want 1 0 00000013",
                     ack0[0], ack1[0], rdata0[0]);
        end
        req0 = 1'b0; req1 = 1'b0;
        step();
        step();
    endtask

    task automatic test_drop_req();
        int pulses = 0;
        do_reset();
        req1 = 1'b1; rw1 = 1'b0; addr1 = 32'h9;
        repeat (5) step();
        checks++;
        if (ack1[1] !== 1'b1 || rdata1[1] !== 32'hA5A5_0009) begin
            errors++;
            $display("FAIL drop_setup got ack1 %0b data %h want 1 a5a50009", ack1[1], rdata1[1]);
        end
        req1 = 1'b0;
        step();
        req0 = 1'b1; rw0 = 1'b0; addr0 = 32'hA;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (i == 2) req0 = 1'b0;
            if (ack0[1]) pulses++;
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL drop_pulses got %0d want 1", pulses);
        end
        checks++;
        if (rdata0[1] !== 32'hA5A5_000A || rdata1[1] !== 32'hA5A5_0009) begin
            errors++;
            $display("FAIL drop_data got %h %h want a5a5000a a5a50009", rdata0[1], rdata1[1]);
        end
    endtask

    initial begin
        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0; rw0 = 1'b0; rw1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        test_reset();
        test_read_lat1();
        test_write_then_read();
        test_round_robin();
        test_lat3();
        test_reset_mid();
        test_drop_req();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
